// File: rtl/seq_shift_pkg.sv
// Shared opcodes and FSM state encodings for the iterative shifter.
package seq_shift_pkg;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift of 0..STEP bits; no state, zero latency, no backpressure.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int K_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] val,
  input  logic [K_W-1:0]   k,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH-1:0] hi_out;  // bit WIDTH-k lands in bit 0
  logic [WIDTH-1:0] lo_out;  // bit k-1 lands in bit 0

  always_comb begin
    res    = val;
    carry  = 1'b0;
    hi_out = val >> (WIDTH - int'(k));
    lo_out = val >> (int'(k) - 1);
    case (op)
      OP_LSL: res = val << k;
      OP_LSR: res = val >> k;
      OP_ASR: res = $unsigned($signed(val) >>> k);
      OP_ROL: res = (val << k) | (val >> (WIDTH - int'(k)));
      default: res = val;
    endcase
    if (k != '0) begin
      if (op == OP_LSL || op == OP_ROL) carry = hi_out[0];
      else                              carry = lo_out[0];
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative LSL/LSR/ASR/ROL unit, up to STEP bits per clock; result ceil(shamt/STEP) edges after accept.
// Holds the result in DONE for as long as out_ready stays low; accepts nothing until it is taken.
module seq_shifter
  import seq_shift_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_r,
  output logic               out_carry,
  output logic               out_zero
);

  localparam int K_W = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_S    = SHAMT_W'(STEP);
  localparam logic [SHAMT_W-1:0] SHAMT_MAX = SHAMT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [1:0]         op_q;
  logic               carry_q;
  logic               zero_q;

  logic [SHAMT_W-1:0] shamt_c;
  logic [SHAMT_W-1:0] k_s;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   step_res;
  logic               step_carry;
  logic               load;
  logic               shift_en;

  // Out-of-range amounts saturate rather than wrap.
  assign shamt_c  = (in_shamt > SHAMT_MAX) ? SHAMT_MAX : in_shamt;
  assign k_s      = (rem_q < STEP_S) ? rem_q : STEP_S;
  assign rem_next = rem_q - k_s;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .K_W   (K_W)
  ) u_step (
    .val   (work_q),
    .k     (K_W'(k_s)),
    .op    (op_q),
    .res   (step_res),
    .carry (step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = (shamt_c != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (rem_next == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero flag is captured alongside the value so it never sees a combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= OP_LSL;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (load) begin
      work_q  <= in_a;
      rem_q   <= shamt_c;
      op_q    <= in_op;
      carry_q <= 1'b0;
      zero_q  <= (in_a == '0);
    end else if (shift_en) begin
      work_q  <= step_res;
      rem_q   <= rem_next;
      carry_q <= step_carry;
      zero_q  <= (step_res == '0);
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_r     = work_q;
  assign out_carry = carry_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=16, STEP=4) with hand-computed results.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [3:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic        out_carry;
  logic        out_zero;

  int vectors     = 0;
  int miscompares = 0;

  seq_shifter #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [3:0] sh,
                        input logic [1:0] op, input logic [15:0] exp_r,
                        input logic exp_c, input logic exp_z, input int exp_lat);
    int lat;
    in_a     = a;
    in_shamt = sh;
    in_op    = op;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a     = 16'hDEAD;
    in_shamt = 4'hF;
    in_op    = 2'b10;
    wait_valid(lat);
    check({tag, ".lat"},   lat,       exp_lat);
    check({tag, ".r"},     out_r,     exp_r);
    check({tag, ".carry"}, out_carry, exp_c);
    check({tag, ".zero"},  out_zero,  exp_z);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".rel_vld"}, out_valid, 1'b0);
    check({tag, ".rel_rdy"}, in_ready,  1'b1);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_shamt  = '0;
    in_op     = 2'b00;
    out_ready = 1'b0;
    #12;
    check("rst.in_ready",  in_ready,  1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.out_r",     out_r,     16'h0000);
    check("rst.carry",     out_carry, 1'b0);
    check("rst.zero",      out_zero,  1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("idle.no_accept", in_ready, 1'b1);

    run_op("lsl12", 16'h000F, 4'd12, 2'b00, 16'hF000, 1'b0, 1'b0, 3);
    run_op("lsr1",  16'h8001, 4'd1,  2'b01, 16'h4000, 1'b1, 1'b0, 1);
    run_op("asr15", 16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, 1'b0, 4);
    run_op("rol4",  16'h1234, 4'd4,  2'b11, 16'h2341, 1'b1, 1'b0, 1);
    run_op("lsl1z", 16'h8000, 4'd1,  2'b00, 16'h0000, 1'b1, 1'b1, 1);
    run_op("sh0",   16'hA5A5, 4'd0,  2'b10, 16'hA5A5, 1'b0, 1'b0, 0);
    run_op("rol7",  16'h8421, 4'd7,  2'b11, 16'h10C2, 1'b0, 1'b0, 2);

    // Backpressure: result held, second operand refused until handshake.
    in_a = 16'h1234; in_shamt = 4'd4; in_op = 2'b11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp.lat", lat, 1);
    in_a = 16'h00F0; in_shamt = 4'd5; in_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      step();
      check("bp.r",     out_r,     16'h2341);
      check("bp.carry", out_carry, 1'b1);
      check("bp.vld",   out_valid, 1'b1);
      check("bp.rdy",   in_ready,  1'b0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp.rel_rdy", in_ready,  1'b1);
    check("bp.rel_vld", out_valid, 1'b0);
    step();
    in_valid = 1'b0;
    check("bp.second_acc", in_ready, 1'b0);
    wait_valid(lat);
    check("bp2.lat",   lat,       2);
    check("bp2.r",     out_r,     16'h0007);
    check("bp2.carry", out_carry, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a shift.
    in_a = 16'h000F; in_shamt = 4'd12; in_op = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("mid.busy", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.out_valid", out_valid, 1'b0);
    check("mid.in_ready",  in_ready,  1'b1);
    check("mid.out_r",     out_r,     16'h0000);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("mid.no_result", out_valid, 1'b0);
    run_op("post", 16'h8000, 4'd1, 2'b00, 16'h0000, 1'b1, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
